// File: rtl/controlador_autenticacao.sv
// Sequencing controller for the combinational authentication circuit: captures code/response,
// checks the returned pattern, grants access, counts failures and enforces a timed lockout.
module controlador_autenticacao #(
  parameter int unsigned MAX_TENTATIVAS = 3,
  parameter int unsigned TEMPO_LIBERADO = 50_000_000,
  parameter int unsigned TEMPO_BLOQUEIO = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirmar,
  input  logic [2:0] codigo,
  input  logic [6:0] senha,
  input  logic [6:0] P,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       acesso_liberado,
  output logic       erro,
  output logic       bloqueado,
  output logic [1:0] tentativas,
  output logic [2:0] estado
);

  localparam int unsigned TW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 7;
  localparam int unsigned NW = 2;

  localparam logic [NW-1:0] MAX_N      = NW'(MAX_TENTATIVAS);
  localparam logic [TW-1:0] CARGA_LIB  = TW'(TEMPO_LIBERADO - 1);
  localparam logic [TW-1:0] CARGA_BLOQ = TW'(TEMPO_BLOQUEIO - 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CAPTURA   = 3'd1,
    VERIFICA  = 3'd2,
    LIBERADO  = 3'd3,
    ERRO      = 3'd4,
    BLOQUEADO = 3'd5
  } estado_t;

  estado_t       state_q, state_d;
  logic          confirmar_q;
  logic [CW-1:0] abc_q, abc_d;
  logic [SW-1:0] senha_q, senha_d;
  logic [NW-1:0] tent_q, tent_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lib_q, lib_d;
  logic          erro_q, erro_d;
  logic          bloq_q, bloq_d;

  logic          inicio;
  logic [NW-1:0] tent_inc;

  assign inicio   = confirmar & ~confirmar_q;
  assign tent_inc = (tent_q < MAX_N) ? NW'(tent_q + NW'(1)) : tent_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OCIOSO;
      confirmar_q <= 1'b0;
      abc_q       <= '0;
      senha_q     <= '0;
      tent_q      <= '0;
      timer_q     <= '0;
      lib_q       <= 1'b0;
      erro_q      <= 1'b0;
      bloq_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      confirmar_q <= confirmar;
      abc_q       <= abc_d;
      senha_q     <= senha_d;
      tent_q      <= tent_d;
      timer_q     <= timer_d;
      lib_q       <= lib_d;
      erro_q      <= erro_d;
      bloq_q      <= bloq_d;
    end
  end

  // Next-state and datapath update; the timer only ever counts down toward zero
  always_comb begin
    state_d = state_q;
    abc_d   = abc_q;
    senha_d = senha_q;
    tent_d  = tent_q;
    timer_d = (timer_q != '0) ? TW'(timer_q - TW'(1)) : timer_q;
    case (state_q)
      OCIOSO: begin
        if (inicio) state_d = CAPTURA;
      end
      CAPTURA: begin
        abc_d   = codigo;
        senha_d = senha;
        state_d = VERIFICA;
      end
      VERIFICA: begin
        if (P == senha_q) begin
          tent_d  = '0;
          timer_d = CARGA_LIB;
          state_d = LIBERADO;
        end else if (tent_inc == MAX_N) begin
          tent_d  = tent_inc;
          timer_d = CARGA_BLOQ;
          state_d = BLOQUEADO;
        end else begin
          tent_d  = tent_inc;
          state_d = ERRO;
        end
      end
      LIBERADO: begin
        if (timer_q == '0) state_d = OCIOSO;
      end
      ERRO: begin
        state_d = OCIOSO;
      end
      BLOQUEADO: begin
        if (timer_q == '0) begin
          tent_d  = '0;
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // Indicator flags registered alongside the state so they track it exactly
  always_comb begin
    lib_d  = 1'b0;
    erro_d = 1'b0;
    bloq_d = 1'b0;
    case (state_d)
      LIBERADO:  lib_d  = 1'b1;
      ERRO:      erro_d = 1'b1;
      BLOQUEADO: bloq_d = 1'b1;
      default: ;
    endcase
  end

  assign A               = abc_q[2];
  assign B               = abc_q[1];
  assign C               = abc_q[0];
  assign acesso_liberado = lib_q;
  assign erro            = erro_q;
  assign bloqueado       = bloq_q;
  assign tentativas      = tent_q;
  assign estado          = 3'(state_q);

endmodule

// File: doc/controlador_autenticacao.md
# controlador_autenticacao

Sequencing controller for the combinational authentication circuit. It captures a 3-bit user code and a 7-bit user response on a confirm press, drives the code into the circuit, and compares the circuit's 7-bit pattern with the response. It grants access on a match, counts failed attempts, and locks out further attempts for a fixed time after too many failures. It sits between the board switches/button and the authentication circuit instance, and drives the access and lockout indicators.

## Interface
- MAX_TENTATIVAS, 3: failed attempts that trigger lockout (legal 1..3).
- TEMPO_LIBERADO, 50_000_000: cycles acesso_liberado stays high.
- TEMPO_BLOQUEIO, 250_000_000: cycles the lockout lasts.

- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- confirmar  input  1  confirm button, level; a rising edge starts an attempt.
- codigo  input  3  user code {A,B,C}.
- senha  input  7  user response to compare.
- P  input  7  pattern returned by the authentication circuit.
- A, B, C  output  1 each  registered code driven into the authentication circuit.
- acesso_liberado  output  1  high while in LIBERADO.
- erro  output  1  one-cycle pulse on a non-locking failure.
- bloqueado  output  1  high while in BLOQUEADO.
- tentativas  output  2  failed-attempt count.
- estado  output  3  current state encoding, for debug.

## Operation
- States, encoded 0..5: OCIOSO, CAPTURA, VERIFICA, LIBERADO, ERRO, BLOQUEADO.
- Edge detect: register confirmar_q <= confirmar. A press is `inicio = confirmar & ~confirmar_q`. confirmar_q updates in every state, so a held button never retriggers.
- OCIOSO: on inicio, go to CAPTURA. Otherwise stay.
- CAPTURA: {A,B,C} <= codigo; senha_reg <= senha. Go to VERIFICA.
- VERIFICA: compare P with senha_reg.
  - Match: tentativas <= 0, load timer, go to LIBERADO.
  - Mismatch with tentativas+1 == MAX_TENTATIVAS: tentativas <= tentativas+1, load timer, go to BLOQUEADO.
  - Other mismatch: tentativas <= tentativas+1, go to ERRO.
- LIBERADO: timer counts down from TEMPO_LIBERADO-1. When it reaches 0, go to OCIOSO.
- ERRO: stays exactly one cycle, then OCIOSO.
- BLOQUEADO: timer counts down from TEMPO_BLOQUEIO-1. When it reaches 0, tentativas <= 0 and go to OCIOSO.
- inicio is ignored in every state except OCIOSO.
- A, B, C hold their last captured value until the next CAPTURA.
- Timer is 32 bits, unsigned, and never wraps: loaded only on entry, decremented only while nonzero.
- tentativas saturates at MAX_TENTATIVAS and cannot overflow.
- Outputs acesso_liberado, erro, bloqueado and estado are decoded from registered state (Moore, glitch-free).

## Timing
- Reset values: state OCIOSO (estado = 0), A = B = C = 0, acesso_liberado = 0, erro = 0, bloqueado = 0, tentativas = 0, timer = 0, senha_reg = 0, confirmar_q = 0.
- Asserting rst mid-operation (including during LIBERADO or BLOQUEADO) clears everything immediately and asynchronously. A lockout does not survive reset.
- Let edge n be the first edge where confirmar = 1 and confirmar_q = 0:
  - n+1: state CAPTURA.
  - n+2: A, B, C valid; state VERIFICA. P must settle within one cycle.
  - n+3: result state is entered, and its output asserts.
- Result durations:
  - acesso_liberado: high for exactly TEMPO_LIBERADO cycles.
  - erro: high for exactly 1 cycle.
  - bloqueado: high for exactly TEMPO_BLOQUEIO cycles.
- Next press accepted: earliest on the first edge after the return to OCIOSO.
- A press that rises on the same edge the block returns to OCIOSO is lost. The bench releases and re-presses.
- codigo and senha are sampled only in CAPTURA. Changes at any other time have no effect.

## Test plan
- Reset: assert rst mid-LIBERADO -> all outputs 0 and estado = 0 immediately, with no clock edge needed.
- Correct code (bench parameters TEMPO_LIBERADO = 4, TEMPO_BLOQUEIO = 8): codigo = 3'b101, senha = 7'b1111111, press -> {A,B,C} = 101 at n+2; acesso_liberado high on cycles n+3..n+6; tentativas = 0.
- Single failure: codigo = 3'b000, senha = 7'b1111111 (circuit returns 7'b1000010) -> erro pulses at n+3 only; tentativas = 1; state back to OCIOSO at n+4.
- Lockout: three wrong attempts -> erro on the 1st and 2nd; on the 3rd, bloqueado high for 8 cycles and tentativas = 3. Presses during the lockout are ignored. Afterwards tentativas = 0, and codigo = 3'b011 with senha = 7'b1111010 is accepted.
- Held button: confirmar held high for 20 cycles -> exactly one attempt is made.
- Input change after capture: change codigo and senha at n+2 -> the result still reflects the values captured at n+1.
